im_port_arbiter: RTL and testbench
==================================

# im_port_arbiter

Two-port arbiter that shares the single-port, word-addressed instruction memory between the fetch stage (read-only) and the program loader (read/write). It sits between the PC/fetch logic and the synchronous instruction-memory array. It grants at most one access per cycle, guarantees loader progress under continuous fetch, and returns read data with fixed one-cycle latency. A loader lock mode gives the loader exclusive access for burst program writes.

## Interface
Parameters:
- ADDR_W, 10, word-index width (memory depth 2^ADDR_W words)
- DATA_W, 32, word width
- STARVE_MAX, 4, consecutive fetch grants allowed while loader waits (≥1)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- f_req  input  1  fetch request
- f_addr  input  32  fetch byte address
- f_gnt  output  1  fetch granted this cycle (combinational)
- f_rvalid  output  1  fetch read data valid
- f_rdata  output  DATA_W  fetch read data
- l_req  input  1  loader request
- l_we  input  1  loader write enable
- l_lock  input  1  loader requests exclusive ownership
- l_addr  input  32  loader byte address
- l_wdata  input  DATA_W  loader write data
- l_gnt  output  1  loader granted this cycle (combinational)
- l_rvalid  output  1  loader read data valid (reads only)
- l_rdata  output  DATA_W  loader read data
- mem_en  output  1  memory access enable
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory word index
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en && !mem_we
- locked  output  1  arbiter is in LOCK state

## Operation
- Word index = addr[ADDR_W+1:2]. Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes. addr[1:0] is ignored unless ALIGN_CHECK is compiled in.
- States: ARB (reset state), LOCK.
- ARB: fetch has priority. The loader is granted when !f_req, or when starve_cnt == STARVE_MAX.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - increments on each f_gnt while l_req is high and not granted;
  - clears on l_gnt, or when l_req is low;
  - saturates at STARVE_MAX.
- ARB→LOCK on a cycle with l_gnt && l_lock. LOCK→ARB on the first cycle with !l_lock; the request in that cycle is arbitrated as ARB.
- LOCK: f_gnt = 0 always; l_gnt = l_req.
- At most one of f_gnt/l_gnt is high. mem_en = f_gnt | l_gnt. mem_we = l_gnt & l_we. mem_addr and mem_wdata are muxed from the granted side.
- Handshake: a requester holds req, addr and wdata stable until it sees gnt. Deasserting req before gnt is legal (request withdrawn).
- Response tag register (owner ∈ {NONE, F, L}) records the granted read. In the next cycle exactly one of f_rvalid/l_rvalid is high, with *_rdata = mem_rdata. Writes produce no rvalid.
- f_rdata/l_rdata are driven with mem_rdata unconditionally; they are meaningful only when the matching rvalid is high.

## Timing
- Grant: combinational, same cycle as req. Read latency: rvalid exactly 1 cycle after gnt. Throughput: 1 access/cycle.
- Reset (async, any time):
  - state = ARB, starve_cnt = 0, owner = NONE;
  - f_rvalid = l_rvalid = locked = 0;
  - an in-flight read is dropped with no rvalid.
  - Combinational outputs follow the inputs immediately after reset.
- Simultaneous f_req & l_req in ARB with starve_cnt < STARVE_MAX → fetch is granted.
- Back-to-back grants to alternating owners are legal. The tag tracks per-cycle ownership, so responses never cross.
- A loader write then a fetch read of the same word in the next cycle returns the new data. Write-first ordering is guaranteed by the sequential memory.

## Configuration
- IM_ARB_ALIGN_CHECK_EN defined:
  - adds output f_err (1 bit, reset 0);
  - a fetch with f_addr[1:0] != 0 is granted normally, but memory is not enabled;
  - in the next cycle f_rvalid = 1, f_err = 1 and f_rdata = 0;
  - loader misalignment is ignored.
- Not defined: f_err is absent and addr[1:0] is silently ignored.

## Structure
- Shared package im_arb_pkg holds:
  - owner enum (OWN_NONE, OWN_F, OWN_L);
  - state enum (ST_ARB, ST_LOCK);
  - the ADDR_W and DATA_W defaults.
- One natural sub-module: im_arb_starve_ctr (saturating starvation counter with a clear input). All other logic stays in the top.

## Test plan
- Fetch-only reads of addr 0x0, 0x4, 0x3FFC on consecutive cycles, with memory preloaded at index i = i → f_gnt each cycle; f_rvalid one cycle later with f_rdata 0, 1, 0x3FF.
- Loader write 0x12345678 to 0x10 while f_req is continuously high, STARVE_MAX=4 → l_gnt on the 5th cycle. A later fetch of 0x10 returns 0x12345678.
- l_lock held high for 8 writes with f_req high throughout → locked=1 after the first l_gnt, f_gnt=0 for the whole burst, return to ARB the cycle after l_lock falls.
- f_addr=0x1004 with ADDR_W=10 → mem_addr=1 (wrap). Under IM_ARB_ALIGN_CHECK_EN, f_addr=0x6 → f_err=1, f_rdata=0, mem_en=0.
- Assert reset the cycle after a loader read grant → no l_rvalid; all registered outputs 0; starve_cnt 0; next f_req granted immediately.

Source files
------------

// File: rtl/im_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package im_arb_pkg;

  // Default geometry of the shared instruction memory
  localparam int unsigned IM_ADDR_W = 10;
  localparam int unsigned IM_DATA_W = 32;

  // Which requester owns the read response returning next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_L    = 2'd2
  } owner_e;

  // Arbiter operating mode
  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // True when a byte address is not on a word boundary
  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return (byte_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/im_arb_starve_ctr.sv
// Saturating starvation counter: counts fetch wins while the loader waits.
module im_arb_starve_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Clear has priority over increment; hold once MAX is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != W'(MAX))) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/im_port_arbiter.sv
// Fetch/loader arbiter for the single-port instruction memory.
// Optional build macro: IM_ARB_ALIGN_CHECK_EN adds f_err and suppresses
// memory access for misaligned fetches.
module im_port_arbiter
  import im_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = IM_ADDR_W,
  parameter int unsigned DATA_W     = IM_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked
`ifdef IM_ARB_ALIGN_CHECK_EN
  ,
  output logic              f_err
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  state_e             state_r, state_nxt_s;
  owner_e             owner_r, owner_nxt_s;
  logic               locked_r;
  logic [CNT_W-1:0]   starve_cnt_s;
  logic               starve_full_s;
  logic               lock_hold_s;
  logic               f_gnt_s, l_gnt_s;
  logic               f_misalign_s;
  logic               mem_en_s;
  logic [ADDR_W-1:0]  f_widx_s, l_widx_s;
  logic [ADDR_W-1:0]  mem_addr_s;
  logic [DATA_W-1:0]  mem_wdata_s;
  logic               unused_addr_s;

  // Word index: byte offset and bits above the memory range are dropped
  assign f_widx_s      = f_addr[ADDR_W+1:2];
  assign l_widx_s      = l_addr[ADDR_W+1:2];
  assign unused_addr_s = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                           l_addr[31:ADDR_W+2], l_addr[1:0]};

`ifdef IM_ARB_ALIGN_CHECK_EN
  assign f_misalign_s = is_misaligned(f_addr[1:0]);
`else
  assign f_misalign_s = 1'b0;
`endif

  // Lock persists only while the loader keeps l_lock high; the release
  // cycle is arbitrated normally.
  assign lock_hold_s   = (state_r == ST_LOCK) && l_lock;
  assign starve_full_s = (starve_cnt_s == CNT_W'(STARVE_MAX));

  // Grant selection: loader exclusive in lock, otherwise fetch first
  // unless the loader has waited STARVE_MAX fetch grants.
  always_comb begin
    f_gnt_s = 1'b0;
    l_gnt_s = 1'b0;
    if (lock_hold_s) begin
      f_gnt_s = 1'b0;
      l_gnt_s = l_req;
    end else if (l_req && starve_full_s) begin
      f_gnt_s = 1'b0;
      l_gnt_s = 1'b1;
    end else if (f_req) begin
      f_gnt_s = 1'b1;
      l_gnt_s = 1'b0;
    end else begin
      f_gnt_s = 1'b0;
      l_gnt_s = l_req;
    end
  end

  // Memory port mux driven from whichever side won this cycle
  always_comb begin
    mem_addr_s  = f_widx_s;
    mem_wdata_s = {DATA_W{1'b0}};
    mem_en_s    = 1'b0;
    if (l_gnt_s) begin
      mem_addr_s  = l_widx_s;
      mem_wdata_s = l_wdata;
      mem_en_s    = 1'b1;
    end else if (f_gnt_s) begin
      mem_addr_s  = f_widx_s;
      mem_wdata_s = {DATA_W{1'b0}};
      mem_en_s    = !f_misalign_s;
    end else begin
      mem_addr_s  = f_widx_s;
      mem_wdata_s = {DATA_W{1'b0}};
      mem_en_s    = 1'b0;
    end
  end

  // Next mode: enter lock on a locked loader grant, leave when l_lock drops
  always_comb begin
    state_nxt_s = ST_ARB;
    if (lock_hold_s) begin
      state_nxt_s = ST_LOCK;
    end else if (l_gnt_s && l_lock) begin
      state_nxt_s = ST_LOCK;
    end else begin
      state_nxt_s = ST_ARB;
    end
  end

  // Response owner for next cycle; writes return nothing
  always_comb begin
    owner_nxt_s = OWN_NONE;
    if (f_gnt_s) begin
      owner_nxt_s = OWN_F;
    end else if (l_gnt_s && !l_we) begin
      owner_nxt_s = OWN_L;
    end else begin
      owner_nxt_s = OWN_NONE;
    end
  end

  im_arb_starve_ctr #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (f_gnt_s && l_req && !l_gnt_s),
    .clr   (l_gnt_s || !l_req),
    .cnt   (starve_cnt_s)
  );

  // Mode, response tag and lock indication registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_ARB;
      owner_r  <= OWN_NONE;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      locked_r <= (state_nxt_s == ST_LOCK);
    end
  end

`ifdef IM_ARB_ALIGN_CHECK_EN
  logic f_err_r;

  // Flag a misaligned fetch in its response cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_err_r <= 1'b0;
    end else begin
      f_err_r <= f_gnt_s && f_misalign_s;
    end
  end

  assign f_err   = f_err_r;
  assign f_rdata = f_err_r ? {DATA_W{1'b0}} : mem_rdata;
`else
  assign f_rdata = mem_rdata;
`endif

  assign f_gnt     = f_gnt_s;
  assign l_gnt     = l_gnt_s;
  assign mem_en    = mem_en_s;
  assign mem_we    = l_gnt_s && l_we;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign f_rvalid  = (owner_r == OWN_F);
  assign l_rvalid  = (owner_r == OWN_L);
  assign l_rdata   = mem_rdata;
  assign locked    = locked_r;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed self-checking bench for im_port_arbiter (STARVE_MAX = 4).
// Honors IM_ARB_ALIGN_CHECK_EN when the design is built with it.
module tb_im_port_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req, f_gnt, f_rvalid;
  logic [31:0]       f_addr;
  logic [DATA_W-1:0] f_rdata;
  logic              l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;
  logic              mem_en, mem_we, locked;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef IM_ARB_ALIGN_CHECK_EN
  logic              f_err;
`endif

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              preload;
  int                n_checks = 0;
  int                n_fail   = 0;
  int                first;

  logic [31:0] fadr [0:2] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_3FFC};
  logic [31:0] fexp [0:2] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_03FF};

  im_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef IM_ARB_ALIGN_CHECK_EN
    .f_err(f_err),
`endif
    .locked(locked)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, preloaded with word i = i
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= DATA_W'(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; preload = 1'b1;
    f_req = 1'b0; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
    @(negedge clk); preload = 1'b0;
    @(negedge clk);
    check("rst_f_rvalid", f_rvalid, 32'd0);
    check("rst_l_rvalid", l_rvalid, 32'd0);
    check("rst_locked",   locked,   32'd0);
    check("rst_mem_en",   mem_en,   32'd0);
    reset = 1'b0;

    // Fetch-only reads on consecutive cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("fetch_rvalid", f_rvalid, 32'd1);
        check("fetch_rdata",  f_rdata,  fexp[i-1]);
      end
      f_req = 1'b1; f_addr = fadr[i]; #1;
      check("fetch_gnt",   f_gnt,    32'd1);
      check("fetch_maddr", mem_addr, fexp[i]);
    end
    @(negedge clk);
    check("fetch_rvalid", f_rvalid, 32'd1);
    check("fetch_rdata",  f_rdata,  fexp[2]);
    check("fetch_l_rvalid", l_rvalid, 32'd0);

    // Loader write under continuous fetch: granted on 5th cycle
    f_req = 1'b1; f_addr = 32'h20;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'h1234_5678;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      check("starve_lgnt", l_gnt, 32'(c == 5));
      check("starve_fgnt", f_gnt, 32'(c != 5));
    end
    check("starve_we",    mem_we,    32'd1);
    check("starve_maddr", mem_addr,  32'd4);
    check("starve_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    check("wr_no_f_rvalid", f_rvalid, 32'd0);
    check("wr_no_l_rvalid", l_rvalid, 32'd0);
    l_req = 1'b0; l_we = 1'b0; f_addr = 32'h10; #1;
    check("rdback_gnt", f_gnt, 32'd1);
    @(negedge clk);
    check("rdback_rvalid", f_rvalid, 32'd1);
    check("rdback_rdata",  f_rdata,  32'h1234_5678);

    // Locked burst of 8 writes with fetch pending throughout
    f_addr = 32'h0;
    l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = 32'h100; l_wdata = 32'hA000_0000;
    first = 0;
    for (int c = 1; c <= 10 && first == 0; c++) begin
      #1;
      if (l_gnt) first = c;
      else begin
        check("lock_wait_locked", locked, 32'd0);
        @(negedge clk);
      end
    end
    check("lock_first_gnt_cycle", first, 32'd5);
    for (int w = 1; w < 8; w++) begin
      @(negedge clk);
      check("lock_locked", locked, 32'd1);
      l_addr = 32'h100 + 32'(4 * w); l_wdata = 32'hA000_0000 + 32'(w); #1;
      check("lock_fgnt",  f_gnt,    32'd0);
      check("lock_lgnt",  l_gnt,    32'd1);
      check("lock_maddr", mem_addr, 32'h40 + 32'(w));
    end
    @(negedge clk);
    l_lock = 1'b0; l_req = 1'b0; l_we = 1'b0; f_addr = 32'h11C; #1;
    check("unlock_locked_still", locked, 32'd1);
    check("unlock_fgnt",         f_gnt,  32'd1);
    @(negedge clk);
    check("unlock_locked", locked,   32'd0);
    check("unlock_rvalid", f_rvalid, 32'd1);
    check("unlock_rdata",  f_rdata,  32'hA000_0007);

    // Address wrap and alternating owners
    f_addr = 32'h1004; #1;
    check("wrap_gnt",   f_gnt,    32'd1);
    check("wrap_maddr", mem_addr, 32'd1);
    @(negedge clk);
    check("wrap_rvalid", f_rvalid, 32'd1);
    check("wrap_rdata",  f_rdata,  32'd1);
    f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8; #1;
    check("lrd_gnt",   l_gnt,    32'd1);
    check("lrd_we",    mem_we,   32'd0);
    check("lrd_maddr", mem_addr, 32'd2);
    @(negedge clk);
    check("lrd_rvalid",   l_rvalid, 32'd1);
    check("lrd_rdata",    l_rdata,  32'd2);
    check("lrd_f_rvalid", f_rvalid, 32'd0);
    l_req = 1'b0; f_req = 1'b1; f_addr = 32'h6; #1;
    check("mis_gnt", f_gnt, 32'd1);
`ifdef IM_ARB_ALIGN_CHECK_EN
    check("mis_mem_en", mem_en, 32'd0);
    @(negedge clk);
    check("mis_rvalid", f_rvalid, 32'd1);
    check("mis_err",    f_err,    32'd1);
    check("mis_rdata",  f_rdata,  32'd0);
`else
    check("mis_mem_en", mem_en,   32'd1);
    check("mis_maddr",  mem_addr, 32'd1);
    @(negedge clk);
    check("mis_rvalid", f_rvalid, 32'd1);
    check("mis_rdata",  f_rdata,  32'd1);
`endif

    // Reset right after a loader read grant drops the response
    f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'hC; #1;
    check("rst_lrd_gnt", l_gnt, 32'd1);
    @(posedge clk); #2;
    reset = 1'b1; l_req = 1'b0;
    @(negedge clk);
    check("rst2_l_rvalid", l_rvalid, 32'd0);
    check("rst2_f_rvalid", f_rvalid, 32'd0);
    check("rst2_locked",   locked,   32'd0);
`ifdef IM_ARB_ALIGN_CHECK_EN
    check("rst2_f_err",    f_err,    32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      check("post_rst_fgnt", f_gnt, 32'(c != 5));
      check("post_rst_lgnt", l_gnt, 32'(c == 5));
    end
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
